// File: rtl/maxpool_5x5_window_pkg.sv
// -----------------------------------------------------------------------------
// maxpool_5x5_window_pkg
// Shared types and constants for the 5x5 stride-1 max-pool window stage.
//   feature_t        : one signed feature sample
//   FEATURE_MOST_NEG : value substituted for every out-of-image tap
//   beat_tag_t       : per-beat side information carried down the pipeline
//   tap_in_range()   : true when position (pos - offset) lies inside [0, size-1]
// -----------------------------------------------------------------------------
package maxpool_5x5_window_pkg;

  localparam int FEATURE_WIDTH   = 16;
  localparam int POOL_CH         = 8;
  localparam int POOL_WINDOW     = 5;
  localparam int POOL_PAD        = 2;
  localparam int POOL_HIST       = POOL_WINDOW - 1;
  localparam int POOL_DATA_WIDTH = POOL_WINDOW * FEATURE_WIDTH;
  localparam int CNT_W           = 10;
  // Positions run to size+1, so they need one bit more than the size fields.
  localparam int POS_W           = CNT_W + 1;

  typedef logic signed [FEATURE_WIDTH-1:0] feature_t;
  typedef logic [CNT_W-1:0]                size_t;
  typedef logic [POS_W-1:0]                pos_t;

  localparam feature_t FEATURE_MOST_NEG = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic valid;   // a real input beat produced this stage entry
    logic emit;    // beat is at r>=2, c>=2 and yields an output pixel
    logic last;    // beat (R+1, C+1): final output of the plane
    logic col_ok;  // current column lies inside the image (c <= C-1)
    pos_t col;     // column index of the beat, drives the history mask
  } beat_tag_t;

  // Evaluates 0 <= pos-offset <= size-1 without signed arithmetic.
  function automatic logic tap_in_range(pos_t pos, int unsigned offset, size_t size);
    logic [POS_W:0] p;
    logic [POS_W:0] off;
    logic [POS_W:0] lim;
    p   = {1'b0, pos};
    off = (POS_W+1)'(offset);
    lim = {2'b00, size} + off;
    return (p >= off) && (p < lim);
  endfunction

endpackage

// File: rtl/maxpool_5x5_window_if.sv
// -----------------------------------------------------------------------------
// maxpool_5x5_window_if
// Data-path bundle between the row cache, the pooling window and its consumer.
//   pool_cache_data/valid : one 5-row column per channel per valid beat
//   pool_out_data/valid   : one pooled pixel per channel
//   pool_done             : pulse with the last output of a plane
//   pool_busy             : plane in progress
// master = upstream/consumer side, slave = pooling window.
// -----------------------------------------------------------------------------
interface maxpool_5x5_window_if;
  import maxpool_5x5_window_pkg::*;

  logic [POOL_DATA_WIDTH*POOL_CH-1:0] pool_cache_data;
  logic                               pool_cache_valid;
  logic [FEATURE_WIDTH*POOL_CH-1:0]   pool_out_data;
  logic                               pool_out_valid;
  logic                               pool_done;
  logic                               pool_busy;

  modport master (
    output pool_cache_data, pool_cache_valid,
    input  pool_out_data, pool_out_valid, pool_done, pool_busy
  );

  modport slave (
    input  pool_cache_data, pool_cache_valid,
    output pool_out_data, pool_out_valid, pool_done, pool_busy
  );

endinterface

// File: rtl/maxpool_5x5_window_max5_signed.sv
// -----------------------------------------------------------------------------
// max5_signed
// Combinational signed maximum of five features.
//   taps    : five signed inputs
//   max_val : largest of them (two's-complement compare)
// -----------------------------------------------------------------------------
module max5_signed
  import maxpool_5x5_window_pkg::*;
(
  input  feature_t taps [POOL_WINDOW],
  output feature_t max_val
);

  // NOTE: combinational blocks use blocking '=' so each loop step sees the
  // running maximum; clocked blocks elsewhere use '<='.
  always_comb begin
    max_val = taps[0];
    for (int i = 1; i < POOL_WINDOW; i++) begin
      if (taps[i] > max_val) max_val = taps[i];
    end
  end

endmodule

// File: rtl/maxpool_5x5_window.sv
// -----------------------------------------------------------------------------
// maxpool_5x5_window
// Stride-1, pad-2, 5x5 max-pool over an 8-channel stream of 5-row columns.
//   system_clk, rst_n     : clock, asynchronous active-low reset
//   pool_start            : pulse; latch sizes, clear state, arm (aborts a plane)
//   row_size, col_size    : real image rows R / cols C (>= 1)
//   bus (slave)           : cache columns in, pooled pixels / done / busy out
// Stage 1 reduces each column vertically with row masking; stage 2 reduces the
// current column and four history columns horizontally with column masking.
// Output for beat (r,c) with r>=2, c>=2 is centre (r-2,c-2), two cycles later.
// -----------------------------------------------------------------------------
module maxpool_5x5_window
  import maxpool_5x5_window_pkg::*;
(
  input  logic  system_clk,
  input  logic  rst_n,
  input  logic  pool_start,
  input  size_t row_size,
  input  size_t col_size,
  maxpool_5x5_window_if.slave bus
);

  size_t     row_q, col_q;
  pos_t      r_q, c_q;
  pos_t      last_row, last_col;
  logic      armed_q;
  logic      busy_q;
  logic      beat;
  beat_tag_t tag_d, s1_tag_q;

  feature_t  v_taps    [POOL_CH][POOL_WINDOW];
  feature_t  v_max     [POOL_CH];
  feature_t  s1_vmax_q [POOL_CH];
  feature_t  hist_q    [POOL_CH][POOL_HIST];
  feature_t  h_taps    [POOL_CH][POOL_WINDOW];
  feature_t  h_max     [POOL_CH];

  logic                             out_valid_q;
  logic                             done_q;
  logic [FEATURE_WIDTH*POOL_CH-1:0] out_data_q;

  assign last_row = pos_t'(row_q) + pos_t'(1);
  assign last_col = pos_t'(col_q) + pos_t'(1);

  // armed_q drops after the final beat so the two-cycle tail ignores input.
  assign beat = bus.pool_cache_valid && armed_q && !pool_start;

  // ---------------------------------------------------------------- position
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      r_q     <= '0;
      c_q     <= '0;
      armed_q <= 1'b0;
    end else if (pool_start) begin
      row_q   <= row_size;
      col_q   <= col_size;
      r_q     <= '0;
      c_q     <= '0;
      armed_q <= 1'b1;
    end else if (beat) begin
      if (c_q == last_col) begin
        c_q <= '0;
        if (r_q == last_row) armed_q <= 1'b0;
        else                 r_q     <= r_q + pos_t'(1);
      end else begin
        c_q <= c_q + pos_t'(1);
      end
    end
  end

  // ------------------------------------------------------- stage 1: vertical
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no path
    // leaves it unassigned (which would infer a latch).
    tag_d        = '0;
    tag_d.valid  = beat;
    tag_d.emit   = (r_q >= pos_t'(POOL_PAD)) && (c_q >= pos_t'(POOL_PAD));
    tag_d.last   = (r_q == last_row) && (c_q == last_col);
    tag_d.col_ok = tap_in_range(c_q, 0, col_q);
    tag_d.col    = c_q;
  end

  // Field k of a channel slice holds row r-k; out-of-image rows are masked.
  always_comb begin
    for (int ch = 0; ch < POOL_CH; ch++) begin
      for (int k = 0; k < POOL_WINDOW; k++) begin
        v_taps[ch][k] = tap_in_range(r_q, k, row_q)
          ? feature_t'(bus.pool_cache_data[ch*POOL_DATA_WIDTH + k*FEATURE_WIDTH +: FEATURE_WIDTH])
          : FEATURE_MOST_NEG;
      end
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tag_q <= '0;
      for (int ch = 0; ch < POOL_CH; ch++) s1_vmax_q[ch] <= FEATURE_MOST_NEG;
    end else begin
      // A start clears the tag, squashing whatever beat was in this stage.
      s1_tag_q <= tag_d;
      if (beat) begin
        for (int ch = 0; ch < POOL_CH; ch++) s1_vmax_q[ch] <= v_max[ch];
      end
    end
  end

  // ----------------------------------------------------- stage 2: horizontal
  // History entry j-1 holds column c-j. The mask derives from the beat's own
  // column, so at c==0 every entry (the previous row's tail) is excluded.
  always_comb begin
    for (int ch = 0; ch < POOL_CH; ch++) begin
      h_taps[ch][0] = s1_tag_q.col_ok ? s1_vmax_q[ch] : FEATURE_MOST_NEG;
      for (int j = 1; j < POOL_WINDOW; j++) begin
        h_taps[ch][j] = tap_in_range(s1_tag_q.col, j, col_q)
          ? hist_q[ch][j-1] : FEATURE_MOST_NEG;
      end
    end
  end

  for (genvar ch = 0; ch < POOL_CH; ch++) begin : g_ch
    max5_signed u_vmax (.taps(v_taps[ch]), .max_val(v_max[ch]));
    max5_signed u_hmax (.taps(h_taps[ch]), .max_val(h_max[ch]));
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the history is a small register array, not a RAM, so it takes
      // the reset value like any other flop.
      for (int ch = 0; ch < POOL_CH; ch++) begin
        for (int j = 0; j < POOL_HIST; j++) hist_q[ch][j] <= FEATURE_MOST_NEG;
      end
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else if (pool_start) begin
      for (int ch = 0; ch < POOL_CH; ch++) begin
        for (int j = 0; j < POOL_HIST; j++) hist_q[ch][j] <= FEATURE_MOST_NEG;
      end
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      out_valid_q <= s1_tag_q.valid && s1_tag_q.emit;
      done_q      <= s1_tag_q.valid && s1_tag_q.emit && s1_tag_q.last;
      if (s1_tag_q.valid) begin
        for (int ch = 0; ch < POOL_CH; ch++) begin
          for (int j = POOL_HIST-1; j > 0; j--) hist_q[ch][j] <= hist_q[ch][j-1];
          hist_q[ch][0] <= s1_vmax_q[ch];
          if (s1_tag_q.emit) out_data_q[ch*FEATURE_WIDTH +: FEATURE_WIDTH] <= h_max[ch];
        end
      end
      if (s1_tag_q.valid && s1_tag_q.emit && s1_tag_q.last) busy_q <= 1'b0;
    end
  end

  assign bus.pool_out_data  = out_data_q;
  assign bus.pool_out_valid = out_valid_q;
  assign bus.pool_done      = done_q;
  assign bus.pool_busy      = busy_q;

endmodule

// File: tb/tb_maxpool_5x5_window.sv
// -----------------------------------------------------------------------------
// tb_maxpool_5x5_window
// Streams padded planes into maxpool_5x5_window and compares every output
// against a direct 5x5 neighbourhood maximum of the stored image.
// -----------------------------------------------------------------------------
module tb_maxpool_5x5_window;
  import maxpool_5x5_window_pkg::*;

  localparam int MAXD = 8;
  localparam int OW   = FEATURE_WIDTH * POOL_CH;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    int            cyc;
  } exp_t;

  logic  system_clk = 1'b0;
  logic  rst_n      = 1'b0;
  logic  pool_start = 1'b0;
  size_t row_size   = '0;
  size_t col_size   = '0;

  maxpool_5x5_window_if bus ();

  maxpool_5x5_window dut (
    .system_clk (system_clk),
    .rst_n      (rst_n),
    .pool_start (pool_start),
    .row_size   (row_size),
    .col_size   (col_size),
    .bus        (bus)
  );

  always #5 system_clk = ~system_clk;

  int       cyc = 0;
  int       n_checks = 0;
  int       n_fail = 0;
  int       n_out = 0;
  int       n_done = 0;
  exp_t     exp_q[$];
  feature_t seen[$];
  feature_t img [POOL_CH][MAXD][MAXD];

  always @(posedge system_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] actual, input logic [159:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Reference: max over the in-image part of the 5x5 neighbourhood.
  function automatic logic [OW-1:0] window_max(int R, int C, int i, int j);
    logic [OW-1:0] res;
    feature_t      m;
    bit            any;
    res = '0;
    for (int ch = 0; ch < POOL_CH; ch++) begin
      m   = '0;
      any = 1'b0;
      for (int y = i - 2; y <= i + 2; y++) begin
        for (int x = j - 2; x <= j + 2; x++) begin
          if (y >= 0 && y < R && x >= 0 && x < C) begin
            if (!any || img[ch][y][x] > m) m = img[ch][y][x];
            any = 1'b1;
          end
        end
      end
      res[ch*FEATURE_WIDTH +: FEATURE_WIDTH] = m;
    end
    return res;
  endfunction

  // Compare process: outputs are sampled on the falling edge.
  always @(negedge system_clk) begin
    exp_t e;
    if (!rst_n) begin
      check("reset_outputs", {bus.pool_out_valid, bus.pool_done, bus.pool_busy, bus.pool_out_data}, '0);
    end else if (bus.pool_out_valid) begin
      n_out++;
      if (bus.pool_done) n_done++;
      if (exp_q.size() == 0) begin
        check("out_unexpected", bus.pool_out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", bus.pool_out_data, e.data);
        check("out_done", bus.pool_done, e.last);
        check("out_latency", cyc, e.cyc);
        seen.push_back(feature_t'(bus.pool_out_data[FEATURE_WIDTH-1:0]));
      end
    end else begin
      check("done_without_valid", bus.pool_done, 1'b0);
      if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        check("out_missing", bus.pool_out_valid, 1'b1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic fill_random();
    for (int ch = 0; ch < POOL_CH; ch++)
      for (int y = 0; y < MAXD; y++)
        for (int x = 0; x < MAXD; x++)
          img[ch][y][x] = feature_t'($urandom);
  endtask

  // Called half a cycle before a falling edge, just after a rising edge.
  task automatic start_plane(int R, int C);
    bus.pool_cache_valid = 1'b0;
    pool_start = 1'b1;
    row_size   = size_t'(R);
    col_size   = size_t'(C);
    // Outputs not yet visible belong to the aborted plane and must not appear.
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i].cyc > cyc) exp_q.delete(i);
    @(posedge system_clk); #1;
    pool_start = 1'b0;
    n_out  = 0;
    n_done = 0;
    seen.delete();
    check("busy_after_start", bus.pool_busy, 1'b1);
  endtask

  task automatic drive_plane(int R, int C, int gap_pct, bit pad_max, int abort_after);
    logic [POOL_DATA_WIDTH*POOL_CH-1:0] d;
    feature_t v;
    int beats = 0;
    for (int r = 0; r <= R + 1; r++) begin
      for (int c = 0; c <= C + 1; c++) begin
        if (abort_after >= 0 && beats == abort_after) begin
          bus.pool_cache_valid = 1'b0;
          return;
        end
        while ($urandom_range(0, 99) < gap_pct) begin
          bus.pool_cache_valid = 1'b0;
          bus.pool_cache_data  = {POOL_CH*POOL_WINDOW/2+1{$urandom}};
          @(posedge system_clk); #1;
        end
        for (int ch = 0; ch < POOL_CH; ch++) begin
          for (int k = 0; k < POOL_WINDOW; k++) begin
            if (r - k >= 0 && r - k < R && c < C) v = img[ch][r-k][c];
            else if (pad_max)                     v = 16'sh7FFF;
            else                                  v = feature_t'($urandom);
            d[ch*POOL_DATA_WIDTH + k*FEATURE_WIDTH +: FEATURE_WIDTH] = v;
          end
        end
        bus.pool_cache_data  = d;
        bus.pool_cache_valid = 1'b1;
        if (r >= 2 && c >= 2)
          exp_q.push_back('{window_max(R, C, r - 2, c - 2), (r == R + 1 && c == C + 1), cyc + 2});
        @(posedge system_clk); #1;
        beats++;
      end
    end
    bus.pool_cache_valid = 1'b0;
  endtask

  task automatic wait_plane(string tag, int R, int C);
    int waited = 0;
    while ((exp_q.size() != 0 || n_done == 0) && waited < 200) begin
      @(posedge system_clk); #1;
      waited++;
    end
    check({tag, "_timeout"}, waited < 200, 1'b1);
    check({tag, "_count"}, n_out, R * C);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_busy_low"}, bus.pool_busy, 1'b0);
  endtask

  task automatic full_plane(string tag, int R, int C, int gap_pct, bit pad_max);
    start_plane(R, C);
    drive_plane(R, C, gap_pct, pad_max, -1);
    wait_plane(tag, R, C);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.pool_cache_valid = 1'b0;
    bus.pool_cache_data  = '0;
    repeat (3) @(posedge system_clk);
    #1 rst_n = 1'b1;
    check("idle_busy", bus.pool_busy, 1'b0);

    // 1x1 image, pads at 0x7FFF must all be masked.
    fill_random();
    img[0][0][0] = 16'sd7;
    full_plane("p1x1", 1, 1, 0, 1'b1);
    check("p1x1_px", seen[0], 16'sd7);

    // 5x5 ramp on channel 0.
    fill_random();
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) img[0][y][x] = feature_t'(y * 5 + x);
    full_plane("p5x5", 5, 5, 0, 1'b0);
    check("p5x5_c00", seen[0], 12);
    check("p5x5_c04", seen[4], 14);
    check("p5x5_c22", seen[12], 24);
    check("p5x5_c44", seen[24], 24);

    // 6x6 negative field with a single higher peak at (3,3).
    for (int ch = 0; ch < POOL_CH; ch++)
      for (int y = 0; y < MAXD; y++)
        for (int x = 0; x < MAXD; x++) img[ch][y][x] = -16'sd100;
    for (int ch = 0; ch < POOL_CH; ch++) img[ch][3][3] = -16'sd5;
    full_plane("p6x6", 6, 6, 0, 1'b0);
    check("p6x6_c00", seen[0], -100);
    check("p6x6_c03", seen[3], -100);
    check("p6x6_c11", seen[7], -5);
    check("p6x6_c35", seen[23], -5);
    check("p6x6_c55", seen[35], -5);

    // Row boundary: large row 0, saturated pads that must never leak.
    fill_random();
    for (int x = 0; x < 3; x++) begin
      img[0][0][x] = 16'sd1000;
      img[0][1][x] = -16'sd1;
      img[0][2][x] = -16'sd1;
    end
    full_plane("p3x3_leak", 3, 3, 0, 1'b1);
    check("p3x3_c00", seen[0], 1000);
    check("p3x3_c10", seen[3], 1000);

    // Random data with ~50% valid gaps.
    fill_random();
    full_plane("p4x7_gaps", 4, 7, 50, 1'b0);

    // Abort after 10 beats, then a full 3x3 plane.
    fill_random();
    start_plane(3, 3);
    drive_plane(3, 3, 0, 1'b0, 10);
    fill_random();
    full_plane("p_abort10", 3, 3, 0, 1'b0);

    // Abort with an output in flight (beat (2,2) is the 13th), then 3x3.
    fill_random();
    start_plane(3, 3);
    drive_plane(3, 3, 0, 1'b0, 13);
    fill_random();
    full_plane("p_abort13", 3, 3, 0, 1'b0);

    // Reset in mid-plane, then a full 3x3 plane.
    fill_random();
    start_plane(3, 3);
    drive_plane(3, 3, 0, 1'b0, 14);
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge system_clk);
    #1 rst_n = 1'b1;
    check("post_reset_busy", bus.pool_busy, 1'b0);
    fill_random();
    full_plane("p_reset", 3, 3, 20, 1'b0);

    repeat (5) @(posedge system_clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool_5x5_window.md
Name: maxpool_5x5_window

Overview:
- Stride-1, pad-2, 5x5 max-pool window stage for the 8-channel pooling path (SPPF-style "same"-size pooling).
- Sits directly downstream of the row cache. Each valid beat delivers one column of 5 vertically stacked rows for 8 channels.
- Keeps a 4-column horizontal history, masks out-of-image taps, and emits one pooled pixel per channel per output position.
- Has no backpressure; it tracks the input stream rate.

Parameters:
- FEATURE_WIDTH, `FEATURE_WIDTH (16): width of one signed feature.
- POOL_CH, 8: channels per beat.
- POOL_DATA_WIDTH, 5*FEATURE_WIDTH: one channel's 5-row column.

Ports:
- system_clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- pool_start  in  1  one-cycle pulse: clear position counters and history, arm for a new plane.
- row_size  in  10  real image rows R (>=1); sampled at pool_start.
- col_size  in  10  real image cols C (>=1); sampled at pool_start.
- pool_cache_data  in  POOL_DATA_WIDTH*POOL_CH  per-channel slice ch at [ch*POOL_DATA_WIDTH +: POOL_DATA_WIDTH]; within a slice, field k (k=0 newest row r ... k=4 oldest row r-4) at [k*FEATURE_WIDTH +: FEATURE_WIDTH].
- pool_cache_valid  in  1  beat valid.
- pool_out_data  out  FEATURE_WIDTH*POOL_CH  pooled result, channel ch at [ch*FEATURE_WIDTH +: FEATURE_WIDTH].
- pool_out_valid  out  1  result valid.
- pool_done  out  1  one-cycle pulse coincident with the last pool_out_valid of the plane.
- pool_busy  out  1  high from pool_start to pool_done.

Behaviour:
- Input framing:
  - The upstream sequencer streams (R+2) rows x (C+2) cols in raster order. The extra two rows and two columns carry don't-care data.
  - The row cache upstream is configured with shift depth C+2.
  - Internal counters r (0..R+1) and c (0..C+1) advance on each pool_cache_valid. c wraps to 0 and r increments at c==C+1.
- Masking: treat every masked tap as the most-negative value, 1 followed by FEATURE_WIDTH-1 zeros.
  - Row tap k is masked if (r-k)<0 or (r-k)>R-1.
  - Column tap j (0 = current column, 1..4 = history) is masked if (c-j)<0 or (c-j)>C-1.
- Stage 1 (registered): per channel, vmax = signed max of the 5 masked row taps. Per-column valid flag = (c<=C-1).
- Stage 2 (registered):
  - Per channel, out = signed max of the current vmax and 4 history vmax entries, with column-masked entries forced to most-negative.
  - History then shifts: newest in, oldest dropped.
  - At c==0 all history entries are treated as masked. This prevents leakage from the previous row.
- Output rule:
  - An output is produced for input beat (r,c) iff r>=2 and c>=2. It represents centre (r-2, c-2).
  - pool_out_valid asserts exactly 2 cycles after that input beat.
  - Exactly R*C outputs per plane, in raster order.
- Comparisons are signed two's-complement and there is no width growth. An all-masked window cannot occur for R,C>=1.
- pool_done: asserted with the output for input beat (R+1, C+1). pool_busy deasserts in the same cycle.
- Beats arriving while pool_busy is low are ignored: no counter advance, no output.
- pool_start while busy: abort. Counters and history clear next cycle. Results still in flight in the pipeline are suppressed (valid cleared), and pool_done is not pulsed for the aborted plane.
- Reset: all outputs 0, counters 0, history = most-negative, pool_busy 0. Reset in mid-plane behaves as an abort.
- Gaps in pool_cache_valid are allowed. The pipeline advances only on valid beats, apart from the 2-cycle output latency, which counts in clock cycles and requires pipeline regs to hold per-beat valid tags.

Decomposition:
- Shared package / parameters.v entries:
  - POOL_CH
  - POOL_WINDOW=5, POOL_PAD=2
  - most-negative feature constant
  - counter width 10
- One sub-module: max5_signed (5-input signed max, combinational). Instantiated per channel for both the vertical and horizontal reductions (16 instances).

Test Plan:
- R=C=1, single real pixel value 7 on ch0, pad beats carrying 0x7FFF: exactly one output = 7, and pool_done coincides with it. Proves pad-data masking.
- R=C=5, ch0 pixel(i,j)=i*5+j: output centre (0,0)=12, (2,2)=24, (4,4)=24, (0,4)=14; 25 outputs, valid 2 cycles after beats r>=2,c>=2.
- R=C=6, all channels = -100 except one -5 at (3,3): outputs = -5 for centres within Chebyshev distance 2 of (3,3), else -100. Checks signed compare and mask value.
- Row-boundary leak: C=3, row 0 all 1000, row 1 all -1: the centre (1,0) output includes 1000 (vertical), but the c==0 history mask blocks the previous row's last columns from entering horizontally. Verify against the reference model on a 3x3 image.
- Random pool_cache_valid gaps (50% duty), R=4, C=7, random data: output stream equals the golden model in order, R*C count, one pool_done.
- Abort: pool_start mid-plane after 10 beats, then a full 3x3 plane: no outputs from the aborted plane emerge after restart, and exactly 9 correct outputs follow. Repeat with rst_n low mid-plane: all outputs 0 during reset.
